// File: rtl/mem_responder_pkg.sv
// Shared constants, decode type and address decoder for mem_responder.
// Holds the I/O window map used by the top and the bench-facing enum.
package mem_responder_pkg;

    localparam logic [31:0] IO_BASE     = 32'h30000;
    localparam logic [31:0] IO_UART     = 32'h30000;
    localparam logic [31:0] IO_HALT     = 32'h30004;
    localparam logic [1:0]  IO_SEL_BITS = 2'b11;

    localparam logic [15:0] OFF_UART = 16'(IO_UART - IO_BASE);
    localparam logic [15:0] OFF_HALT = 16'(IO_HALT - IO_BASE);

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_UART,
        DEC_HALT,
        DEC_OTHER
    } dec_t;

    // Bits above 17 never take part in the decode.
    function automatic dec_t decode(input logic [17:0] a);
        if (a[17:16] != IO_SEL_BITS) return DEC_RAM;
        if (a[15:0] == OFF_UART)     return DEC_UART;
        if (a[15:0] == OFF_HALT)     return DEC_HALT;
        return DEC_OTHER;
    endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Byte FIFO with wrapping pointers and an explicit occupancy count.
// Ports: clk, rst, push/din, pop/dout, empty, full, count (0..DEPTH).
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A pop frees the slot in the same edge, so a push into a full
    // FIFO is accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte RAM plus UART TX/RX FIFOs and halt flag.
// Ports: mem_a/mem_dout/mem_wr/mem_din request bus, cpu_rdy stall,
// tx_* and rx_* UART streams, sticky halt and tx_ovf flags.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        cpu_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_full,
    output logic        halt,
    output logic        tx_ovf
);

    localparam int TW = $clog2(TX_DEPTH);
    localparam int RW = $clog2(RX_DEPTH);

    logic [7:0]        ram [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    dec_t              dec;
    logic              accept;
    logic              rd;
    logic [7:0]        io_rdata;
    logic              unused_hi;

    logic              tx_push;
    logic              tx_pop;
    logic              tx_push_ok;
    logic              tx_empty;
    logic              tx_full;
    logic [TW:0]       tx_count;
    logic [TW:0]       tx_count_next;

    logic              rx_pop;
    logic              rx_empty;
    logic [7:0]        rx_head;
    logic [RW:0]       rx_level_unused;

    assign unused_hi = ^mem_a[31:18];

    assign idx    = mem_a[ADDR_W-1:0];
    assign dec    = decode(mem_a[17:0]);
    assign accept = cpu_rdy;
    assign rd     = accept && !mem_wr;

    // A TX data store lands even in the cycle cpu_rdy is low: the store
    // issued alongside the deassertion is already in flight, and the
    // slot reserved by the DEPTH-1 threshold is there to catch it.
    assign tx_push    = mem_wr && (dec == DEC_UART);
    assign tx_pop     = tx_valid && tx_ready;
    assign tx_push_ok = tx_push && (!tx_full || tx_pop);
    assign tx_valid   = !tx_empty;

    assign rx_pop = rd && (dec == DEC_UART) && !rx_empty;

    always_comb begin
        tx_count_next = tx_count;
        if (tx_push_ok && !tx_pop)
            tx_count_next = tx_count + 1'b1;
        else if (!tx_push_ok && tx_pop)
            tx_count_next = tx_count - 1'b1;
    end

    always_comb begin
        io_rdata = 8'h00;
        unique case (dec)
            DEC_UART: io_rdata = rx_empty ? 8'h00 : rx_head;
            DEC_HALT: io_rdata = {7'b0, !rx_empty};
            default:  io_rdata = 8'h00;
        endcase
    end

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (mem_dout),
        .pop   (tx_pop),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_level_unused)
    );

    always_ff @(posedge clk) begin
        if (accept && mem_wr && (dec == DEC_RAM))
            ram[idx] <= mem_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_din <= 8'h00;
            cpu_rdy <= 1'b1;
            halt    <= 1'b0;
            tx_ovf  <= 1'b0;
        end else begin
            cpu_rdy <= (tx_count_next < (TW+1)'(TX_DEPTH - 1));
            if (tx_push && !tx_push_ok)
                tx_ovf <= 1'b1;
            if (accept && mem_wr && (dec == DEC_HALT))
                halt <= 1'b1;
            if (rd)
                mem_din <= (dec == DEC_RAM) ? ram[idx] : io_rdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: queue/array reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_mem_responder;

    localparam int TXD = 8;
    localparam int RXD = 8;
    localparam logic [31:0] IDLE_A = 32'h30008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_a = IDLE_A;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        cpu_rdy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_full;
    logic        halt;
    logic        tx_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_a    (mem_a),
        .mem_dout (mem_dout),
        .mem_wr   (mem_wr),
        .mem_din  (mem_din),
        .cpu_rdy  (cpu_rdy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_full  (rx_full),
        .halt     (halt),
        .tx_ovf   (tx_ovf)
    );

    task automatic check8(input string name, input logic [7:0] got,
                          input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got,
                          input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    // Reference model
    logic [7:0] m_ram [int];
    logic [7:0] m_tx [$];
    logic [7:0] m_rx [$];
    logic [7:0] m_din;
    logic       m_rdy;
    logic       m_halt;
    logic       m_ovf;
    logic [7:0] got_tx [$];

    task automatic model_step();
        bit io, uart, hs, acc, txpop, rxpop;
        int key;
        if (rst) begin
            m_tx.delete();
            m_rx.delete();
            m_din  = 8'h00;
            m_rdy  = 1'b1;
            m_halt = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            acc   = m_rdy;
            io    = (mem_a[17:16] == 2'b11);
            uart  = io && (mem_a[15:0] == 16'h0000);
            hs    = io && (mem_a[15:0] == 16'h0004);
            key   = int'(mem_a[16:0]);
            txpop = (m_tx.size() > 0) && tx_ready;
            rxpop = 1'b0;
            if (acc && !mem_wr) begin
                if (!io)
                    m_din = m_ram[key];
                else if (uart) begin
                    if (m_rx.size() > 0) begin
                        m_din = m_rx[0];
                        rxpop = 1'b1;
                    end else
                        m_din = 8'h00;
                end else if (hs)
                    m_din = (m_rx.size() > 0) ? 8'h01 : 8'h00;
                else
                    m_din = 8'h00;
            end
            if (acc && mem_wr && !io) m_ram[key] = mem_dout;
            if (acc && mem_wr && hs) m_halt = 1'b1;
            if (txpop) void'(m_tx.pop_front());
            if (mem_wr && uart) begin
                if (m_tx.size() < TXD) m_tx.push_back(mem_dout);
                else m_ovf = 1'b1;
            end
            if (rxpop) void'(m_rx.pop_front());
            if (rx_valid && m_rx.size() < RXD) m_rx.push_back(rx_data);
            m_rdy = (m_tx.size() < TXD - 1);
        end
    endtask

    initial begin
        m_din = 8'h00; m_rdy = 1'b1; m_halt = 1'b0; m_ovf = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check8("mem_din", mem_din, m_din);
            check1("cpu_rdy", cpu_rdy, m_rdy);
            check1("tx_valid", tx_valid, m_tx.size() > 0);
            if (m_tx.size() > 0) check8("tx_data", tx_data, m_tx[0]);
            check1("rx_full", rx_full, m_rx.size() == RXD);
            check1("halt", halt, m_halt);
            check1("tx_ovf", tx_ovf, m_ovf);
            if (tx_valid && tx_ready) got_tx.push_back(tx_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic req(input logic [31:0] a, input logic [7:0] d,
                       input logic w);
        mem_a    = a;
        mem_dout = d;
        mem_wr   = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) req(IDLE_A, 8'h00, 1'b0);
    endtask

    logic [7:0] wv [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] drain [9] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54,
                              8'h55, 8'h56, 8'h57, 8'h9A};

    initial begin
        int n;
        @(posedge clk);
        #1;
        check8("rst_din", mem_din, 8'h00);
        check1("rst_rdy", cpu_rdy, 1'b1);
        check1("rst_txv", tx_valid, 1'b0);
        check1("rst_rxf", rx_full, 1'b0);
        check1("rst_halt", halt, 1'b0);
        check1("rst_ovf", tx_ovf, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // RAM write then streaming read
        for (int i = 0; i < 4; i++) req(32'h100 + i, wv[i], 1'b1);
        for (int i = 0; i < 4; i++) begin
            req(32'h100 + i, 8'h00, 1'b0);
            check8("ram_rd", mem_din, wv[i]);
        end
        idle(1);

        // TX pass-through with the UART ready
        tx_ready = 1'b1;
        got_tx.delete();
        for (int i = 0; i < 4; i++) req(32'h30000, 8'(65 + i), 1'b1);
        idle(3);
        check8("tx_n", 8'(got_tx.size()), 8'd4);
        for (int i = 0; i < 4 && i < got_tx.size(); i++)
            check8("tx_seq", got_tx[i], 8'(65 + i));
        check1("tx_ovf0", tx_ovf, 1'b0);

        // Fill TX with the UART stalled
        tx_ready = 1'b0;
        got_tx.delete();
        for (int i = 0; i < 8; i++) begin
            req(32'h30000, 8'(80 + i), 1'b1);
            if (i == 5) check1("rdy_at6", cpu_rdy, 1'b1);
            if (i == 6) check1("rdy_at7", cpu_rdy, 1'b0);
        end
        check1("rdy_full", cpu_rdy, 1'b0);
        check1("ovf_full", tx_ovf, 1'b0);

        // Overflow, then push+pop at full
        req(32'h30000, 8'h99, 1'b1);
        check1("ovf_set", tx_ovf, 1'b1);
        tx_ready = 1'b1;
        req(32'h30000, 8'h9A, 1'b1);
        check1("rdy_pp", cpu_rdy, 1'b0);
        check1("txv_pp", tx_valid, 1'b1);
        mem_wr = 1'b0;
        mem_a  = IDLE_A;
        n = 0;
        while (!cpu_rdy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check1("rdy_back", cpu_rdy, 1'b1);
        check8("rdy_lat", 8'(n), 8'd2);
        idle(10);
        check8("drain_n", 8'(got_tx.size()), 8'd9);
        for (int i = 0; i < 9 && i < got_tx.size(); i++)
            check8("drain_seq", got_tx[i], drain[i]);

        // RX path
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        idle(1);
        rx_data  = 8'hBB;
        idle(1);
        rx_valid = 1'b0;
        req(32'h30004, 8'h00, 1'b0);
        check8("rx_stat", mem_din, 8'h01);
        req(32'h30000, 8'h00, 1'b0);
        check8("rx_aa", mem_din, 8'hAA);
        req(32'h30000, 8'h00, 1'b0);
        check8("rx_bb", mem_din, 8'hBB);
        req(32'h30000, 8'h00, 1'b0);
        check8("rx_empty", mem_din, 8'h00);
        req(32'h30004, 8'h00, 1'b0);
        check8("rx_stat0", mem_din, 8'h00);

        // RX overfill
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'(192 + i);
            idle(1);
        end
        rx_valid = 1'b0;
        check1("rx_full", rx_full, 1'b1);
        req(32'h30000, 8'h00, 1'b0);
        check8("rx_c0", mem_din, 8'hC0);
        check1("rx_nfull", rx_full, 1'b0);

        // Halt, then reset mid-stream
        req(32'h30004, 8'h00, 1'b1);
        check1("halt_set", halt, 1'b1);
        req(32'h100, 8'h00, 1'b0);
        check8("halt_rd", mem_din, 8'h12);
        tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) req(32'h30000, 8'(97 + i), 1'b1);
        check1("pre_rdy", cpu_rdy, 1'b0);
        check1("pre_ovf", tx_ovf, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        idle(2);
        rx_valid = 1'b0;
        check1("pre_rxf", rx_full, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check1("ar_halt", halt, 1'b0);
        check1("ar_ovf", tx_ovf, 1'b0);
        check1("ar_txv", tx_valid, 1'b0);
        check1("ar_rxf", rx_full, 1'b0);
        check8("ar_din", mem_din, 8'h00);
        check1("ar_rdy", cpu_rdy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        req(32'h100, 8'h00, 1'b0);
        check8("ram_kept", mem_din, 8'h12);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's byte-serial memory controller.
- Decodes the controller's byte requests (address, data out, write-enable).
- Serves each request from a byte-wide synchronous RAM or from a memory-mapped I/O window.
- The I/O window provides a TX byte FIFO toward the UART transmitter, an RX byte FIFO from the UART receiver, and a halt register.
- Drives the CPU-wide rdy so the core stalls while the TX path is full.

Parameters:
ADDR_W, 17, RAM byte-address width (RAM holds 2^ADDR_W bytes)
TX_DEPTH, 8, TX FIFO depth in bytes (power of 2, >=2)
RX_DEPTH, 8, RX FIFO depth in bytes (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_a  in  32  byte address from the memory controller
mem_dout  in  8  write data from the memory controller
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data to the memory controller
cpu_rdy  out  1  global CPU ready; 0 stalls the core
tx_data  out  8  byte to the UART transmitter
tx_valid  out  1  tx_data valid (TX FIFO not empty)
tx_ready  in  1  UART accepts tx_data this cycle
rx_data  in  8  byte from the UART receiver
rx_valid  in  1  rx_data valid; pushed into the RX FIFO
rx_full  out  1  RX FIFO full
halt  out  1  sticky program-end flag
tx_ovf  out  1  sticky TX overflow flag

Behaviour:
- Address decode:
  - io_sel = (mem_a[17:16] == 2'b11).
  - RAM index = mem_a[ADDR_W-1:0]; upper address bits are ignored.
- Request acceptance: a request is accepted on a rising clk edge only when cpu_rdy = 1. When cpu_rdy = 0 the request is ignored and mem_din holds its value.
- RAM read: mem_din <= ram[idx] at the edge. Data is valid exactly 1 cycle after the address is presented, so back-to-back addresses stream one byte per cycle.
- RAM write: ram[idx] <= mem_dout at the edge. mem_din is left unchanged on a write.
- I/O read at 0x30000:
  - mem_din <= RX head byte and the RX FIFO pops.
  - If RX is empty, mem_din <= 8'h00 and there is no pop.
- I/O read at 0x30004: mem_din <= {7'b0, rx_nonempty}, a status byte.
- I/O read at any other I/O address: mem_din <= 8'h00.
- I/O write at 0x30000:
  - Pushes mem_dout into the TX FIFO.
  - If TX is full, the byte is dropped and tx_ovf is set.
- I/O write at 0x30004: halt <= 1 (sticky until reset). halt never blocks further requests.
- I/O writes to any other address are ignored.
- TX FIFO:
  - tx_valid = !empty; tx_data = head byte, combinational from storage.
  - Pops when tx_valid && tx_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - A push while full is dropped, but a push in the same cycle as a pop from a full FIFO succeeds.
- RX FIFO:
  - Pushes on rx_valid; a push while full is dropped (no flag).
  - Simultaneous rx push and CPU pop behave like the TX case.
  - rx_full = (count == RX_DEPTH).
- cpu_rdy:
  - Registered: cpu_rdy <= (tx_count_next < TX_DEPTH-1).
  - It drops to 0 once the TX FIFO holds DEPTH-1 bytes. This leaves one slot for the store byte already in flight during the cycle of deassertion.
  - It returns to 1 the cycle after a drain brings the count back below DEPTH-1.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (asynchronous, any time including mid-burst):
  - mem_din = 0, cpu_rdy = 1, halt = 0, tx_ovf = 0.
  - Both FIFOs empty (pointers and counts 0), so tx_valid = 0 and rx_full = 0.
  - RAM contents are not reset.
  - The first request is accepted on the first edge after rst falls.

Decomposition:
- Shared package constants: IO_BASE 32'h30000, IO_UART 32'h30000, IO_HALT 32'h30004, IO_SEL_BITS 2'b11.
- One natural sub-module, byte_fifo(DEPTH):
  - Ports: clk, rst, push, din, pop, dout, empty, full, count.
  - Instantiated once for TX and once for RX.
- RAM inference, decode, cpu_rdy and the flags live in mem_responder.

Test Plan:
- Write 0x12,0x34,0x56,0x78 to 0x100..0x103, then read the same addresses back to back -> mem_din = 0x12,0x34,0x56,0x78 on the 4 consecutive cycles, each lagging its address by 1 cycle.
- 4 TX writes 0x41..0x44 to 0x30000 with tx_ready=1 -> tx_data/tx_valid present 0x41..0x44 in order; tx_ovf = 0.
- tx_ready=0, TX_DEPTH=8, 8 writes to 0x30000 -> cpu_rdy falls the cycle after the 7th push. The 8th byte (in flight) is stored and count = 8. Raising tx_ready drains the FIFO and cpu_rdy returns to 1 once count < 7.
- Force a write to 0x30000 with TX full and tx_ready=0 -> byte dropped, tx_ovf = 1; a simultaneous push and pop at full keeps count = 8.
- RX: push 0xAA, 0xBB via rx_valid, then read 0x30004, 0x30000, 0x30000, 0x30000 -> status 0x01, then 0xAA, 0xBB, 0x00.
- Write to 0x30004 -> halt = 1. Assert rst mid-stream -> halt, tx_ovf, FIFOs and mem_din all cleared immediately; cpu_rdy = 1; RAM byte at 0x100 still reads 0x12.
